// File: rtl/seg7_scan_capture.sv
// ============================================================================
//  Module      : seg7_scan_capture
//  Description : Recovers an 8-digit hex frame from a multiplexed, active-low
//                7-segment display bus by debouncing each (an, seg) pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_capture #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  seg,
    input  logic [7:0]  an,
    output logic [31:0] value,
    output logic [7:0]  blank,
    output logic        err,
    output logic        valid,
    output logic        busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_COLLECT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [7:0] c_stable    = 8'(STABLE);
    localparam logic [7:0] c_accept_at = 8'(STABLE - 2);

    // Decoded digit: {unrecognised, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] d;
        case (s)
            7'h40:   d = 6'h00;
            7'h79:   d = 6'h01;
            7'h24:   d = 6'h02;
            7'h30:   d = 6'h03;
            7'h19:   d = 6'h04;
            7'h12:   d = 6'h05;
            7'h02:   d = 6'h06;
            7'h78:   d = 6'h07;
            7'h00:   d = 6'h08;
            7'h10:   d = 6'h09;
            7'h08:   d = 6'h0A;
            7'h03:   d = 6'h0B;
            7'h46:   d = 6'h0C;
            7'h21:   d = 6'h0D;
            7'h06:   d = 6'h0E;
            7'h0E:   d = 6'h0F;
            7'h7F:   d = 6'b01_0000;
            default: d = 6'b10_0000;
        endcase
        return d;
    endfunction

    logic [1:0]  r_state;
    logic [7:0]  r_prev_an;
    logic [6:0]  r_prev_seg;
    logic [7:0]  r_cnt;
    logic [7:0]  r_mask;
    logic [31:0] r_sh_value;
    logic [7:0]  r_sh_blank;
    logic [7:0]  r_sh_err;
    logic [31:0] r_value;
    logic [7:0]  r_blank;
    logic        r_err;
    logic        r_valid;

    logic [7:0]  w_sel;
    logic        w_an_ok;
    logic [2:0]  w_digit;
    logic        w_changed;
    logic        w_accept;
    logic [5:0]  w_dec;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic        w_bad;
    logic [7:0]  w_digit_bit;
    logic [7:0]  w_mask_next;

    always_comb begin
        w_sel   = ~an;
        w_an_ok = (w_sel != 8'h00) && ((w_sel & (w_sel - 8'd1)) == 8'h00);
        w_digit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel[i]) begin
                w_digit = 3'(i);
            end
        end
        w_changed   = (an != r_prev_an) || (seg != r_prev_seg);
        // STABLE equal samples: counter was cleared on the first one
        w_accept    = w_an_ok && !w_changed && (r_cnt == c_accept_at);
        w_dec       = decode(seg);
        w_nib       = w_dec[3:0];
        w_blank     = w_dec[4];
        w_bad       = w_dec[5];
        w_digit_bit = 8'h01 << w_digit;
        w_mask_next = r_mask | w_digit_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_an  <= 8'hFF;
            r_prev_seg <= 7'h7F;
            r_cnt      <= 8'd0;
        end else begin
            r_prev_an  <= an;
            r_prev_seg <= seg;
            if (w_changed || !w_an_ok) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mask     <= 8'h00;
            r_sh_value <= 32'h0;
            r_sh_blank <= 8'h00;
            r_sh_err   <= 8'h00;
            r_value    <= 32'h0;
            r_blank    <= 8'h00;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_accept && (w_digit == 3'd0)) begin
                        r_sh_value <= {28'h0, w_nib};
                        r_sh_blank <= {7'h00, w_blank};
                        r_sh_err   <= {7'h00, w_bad};
                        r_mask     <= 8'h01;
                        r_state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        // Per-digit error bits so a re-accepted digit replaces its contribution
                        r_sh_value[w_digit*4 +: 4] <= w_nib;
                        r_sh_blank[w_digit]        <= w_blank;
                        r_sh_err[w_digit]          <= w_bad;
                        r_mask                     <= w_mask_next;
                        if (w_mask_next == 8'hFF) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_value <= r_sh_value;
                    r_blank <= r_sh_blank;
                    r_err   <= |r_sh_err;
                    r_valid <= 1'b1;
                    r_state <= en ? S_SYNC : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign value = r_value;
    assign blank = r_blank;
    assign err   = r_err;
    assign valid = r_valid;
    assign busy  = (r_state == S_SYNC) || (r_state == S_COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
// ============================================================================
//  Module      : tb_seg7_scan_capture
//  Description : Scoreboard bench for seg7_scan_capture with directed scans.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_capture;

    typedef struct packed {
        logic [31:0] v;
        logic [7:0]  b;
        logic        e;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] value;
    logic [7:0]  blank;
    logic        err;
    logic        valid;
    logic        busy;

    int     checks;
    int     errors;
    frame_t exp_q[$];

    seg7_scan_capture #(.STABLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .seg   (seg),
        .an    (an),
        .value (value),
        .blank (blank),
        .err   (err),
        .valid (valid),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [55:0] pats_of(input logic [31:0] nibs);
        logic [55:0] p;
        for (int d = 0; d < 8; d++) p[d*7 +: 7] = seg_of(nibs[d*4 +: 4]);
        return p;
    endfunction

    // Called aligned #1 after a rising edge; each digit is sampled on `hold` edges
    task automatic scan(input logic [55:0] pats, input int hold, input int first,
                        input int last, input int gap);
        for (int d = first; d <= last; d++) begin
            an  = ~(8'h01 << d);
            seg = pats[d*7 +: 7];
            repeat (hold) @(posedge clk);
            #1;
            if (gap > 0) begin
                an = 8'hFC;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        an  = 8'hFF;
        seg = 7'h7F;
    endtask

    task automatic push(input logic [31:0] v, input logic [7:0] b, input logic e);
        frame_t f;
        f.v = v;
        f.b = b;
        f.e = e;
        exp_q.push_back(f);
    endtask

    task automatic drain_check(input string name);
        repeat (4) @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every valid pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("value", value, f.v);
                chk("blank", {24'h0, blank}, {24'h0, f.b});
                chk("err", {31'h0, err}, {31'h0, f.e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [55:0] p;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        an     = 8'hFF;
        seg    = 7'h7F;
        repeat (3) @(negedge clk);
        chk("rst_value", value, 32'h0);
        chk("rst_blank", {24'h0, blank}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;

        // Basic frame 1..8
        en = 1'b1;
        @(posedge clk);
        #1;
        push(32'h87654321, 8'h00, 1'b0);
        scan(pats_of(32'h87654321), 4, 0, 7, 0);
        drain_check("frame_basic_seen");

        // Scan begins mid-frame; digits 3..7 ignored until digit 0
        push(32'h10FEDCBA, 8'h00, 1'b0);
        scan(pats_of(32'h10FEDCBA), 4, 3, 7, 0);
        scan(pats_of(32'h10FEDCBA), 4, 0, 7, 0);
        drain_check("frame_midstart_seen");

        // Blank on digit 2, unrecognised pattern on digit 5
        p = pats_of(32'h87654321);
        p[2*7 +: 7] = 7'h7F;
        p[5*7 +: 7] = 7'h55;
        push(32'h87054021, 8'h04, 1'b1);
        scan(p, 4, 0, 7, 0);
        drain_check("frame_blank_err_seen");

        // Too-short holds, then short holds separated by invalid selects
        scan(pats_of(32'h11111111), 3, 0, 7, 0);
        scan(pats_of(32'h22222222), 3, 0, 7, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("short_busy", {31'h0, busy}, 32'h1);
        chk("short_value_kept", value, 32'h87054021);

        // Abort after digit 4, then restart
        scan(pats_of(32'h12345678), 4, 0, 4, 0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_value_kept", value, 32'h87054021);
        chk("abort_blank_kept", {24'h0, blank}, 32'h04);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_busy", {31'h0, busy}, 32'h1);
        push(32'h12345678, 8'h00, 1'b0);
        scan(pats_of(32'h12345678), 4, 0, 7, 0);
        drain_check("frame_restart_seen");

        // Asynchronous reset in the middle of collection
        scan(pats_of(32'hFEDCBA98), 4, 0, 2, 0);
        an  = ~8'h08;
        seg = seg_of(4'hB);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_value", value, 32'h0);
        chk("arst_blank", {24'h0, blank}, 32'h0);
        chk("arst_err", {31'h0, err}, 32'h0);
        chk("arst_valid", {31'h0, valid}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        an  = 8'hFF;
        seg = 7'h7F;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'hFEDCBA98, 8'h00, 1'b0);
        scan(pats_of(32'hFEDCBA98), 4, 0, 7, 0);
        drain_check("frame_after_reset_seen");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE, default 4, is the consecutive cycles an (an, seg) pair must hold before the digit is accepted; legal range 2..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  capture enable; high starts and continues frame capture.
REQ-005 seg  input  7  active-low segment bus, seg[0]=a .. seg[6]=g.
REQ-006 an  input  8  active-low digit select; an[i]=0 selects digit i.
REQ-007 value  output  32  captured frame; nibble i (bits 4i+3:4i) holds digit i.
REQ-008 blank  output  8  bit i set when digit i was blank (seg=7'h7F).
REQ-009 err  output  1  set when the last frame contained at least one unrecognised pattern.
REQ-010 valid  output  1  one-cycle pulse when value/blank/err update.
REQ-011 busy  output  1  high in SYNC and COLLECT.

Function
REQ-012 Decode table (seg hex -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-013 seg=7F decodes to nibble 0 with the blank bit set; any other unlisted pattern decodes to nibble 0 and sets the frame error flag.
REQ-014 an is valid only when exactly one bit is 0; otherwise the stability counter clears and nothing is accepted (not an error).
REQ-015 Stability counter: clears on any change of an or seg versus the previous cycle; otherwise it increments, saturating at STABLE.
REQ-016 Acceptance: a digit is accepted in the cycle the counter reaches STABLE-1 with the pair unchanged (STABLE equal consecutive samples); a held pair is accepted only once.
REQ-017 FSM states: IDLE, SYNC, COLLECT, DONE.
REQ-018 IDLE: en=1 -> SYNC.
REQ-019 SYNC: waits for acceptance of digit 0; on it, stores digit 0, clears the collected mask, blank and error accumulators, sets mask bit 0, and goes to COLLECT; other digits are ignored.
REQ-020 COLLECT: each accepted digit i writes its nibble, blank bit and error contribution into the shadow registers and sets mask bit i; re-acceptance of a digit overwrites it.
REQ-021 COLLECT: when the mask becomes 8'hFF -> DONE.
REQ-022 DONE, one cycle: copies shadow registers to value/blank/err, asserts valid, then -> SYNC if en=1, else IDLE.
REQ-023 en=0 in SYNC or COLLECT aborts the frame -> IDLE next cycle; outputs retain their previous frame and valid is not asserted.
REQ-024 Outputs change only in DONE; value, blank and err are stable between valid pulses.
REQ-025 Minimum latency: 8*STABLE cycles from the first sample of digit 0 to valid, plus 1 cycle for DONE.

Reset
REQ-026 rst_n=0 asynchronously forces: state IDLE, counter 0, mask 0, value 32'h0, blank 8'h00, err 0, valid 0, busy 0.
REQ-027 Reset asserted mid-frame discards the partial frame; after release, capture restarts from SYNC only once en=1 is seen in IDLE.

Verification
REQ-028 STABLE=4, en=1; scan digits 0..7 (each held 4 cycles) with patterns for 1,2,3,4,5,6,7,8 -> one valid pulse; value=32'h87654321, blank=00, err=0.
REQ-029 Scan starting at digit 3 (3..7, then 0..7) -> digits 3..7 ignored until digit 0 is accepted; valid only after the full 0..7 pass.
REQ-030 Digit 2 shows seg=7F and digit 5 shows seg=7'h55 -> value nibbles 2 and 5 = 0; blank=8'h04; err=1.
REQ-031 Each digit held 3 cycles with STABLE=4, or an=8'hFF/8'hFC between digits -> no acceptance, busy stays 1, valid never pulses.
REQ-032 en dropped after digit 4 is accepted -> IDLE, previous value retained, no valid pulse; re-raising en restarts at SYNC.
REQ-033 rst_n pulsed low mid-COLLECT, asynchronously to clk -> all outputs zero immediately; the next full scan yields a correct frame.
